// File: rtl/riscv_decode_if.sv
// riscv_decode_if
//   Bundles the decode stage's bus signals: the instruction handshake
//   (inst_valid/inst_ready/inst), the execute-stage payload and handshake
//   (ex_*), the register writeback port (wb_*) and the illegal pulse.
//   slave  : the decode stage itself.
//   master : whoever drives instructions/writebacks and consumes the payload.
interface riscv_decode_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_is_imm;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  modport slave (
    input  inst_valid, inst, ex_ready, wb_en, wb_rd, wb_data,
    output inst_ready, ex_valid, ex_a, ex_b, ex_is_imm, ex_funct7, ex_funct3,
           ex_rd, illegal
  );

  modport master (
    output inst_valid, inst, ex_ready, wb_en, wb_rd, wb_data,
    input  inst_ready, ex_valid, ex_a, ex_b, ex_is_imm, ex_funct7, ex_funct3,
           ex_rd, illegal
  );
endinterface

// File: rtl/riscv_decode.sv
// riscv_decode
//   Decode/issue stage for the integer ALU. Accepts OP, OP-IMM and LUI
//   instructions, reads the 32x32 register file, builds the immediate and
//   registers the ALU operands for the execute stage. A per-register pending
//   scoreboard, cleared by the writeback port, stalls read-after-write hazards.
//
// Ports
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : riscv_decode_if.slave (instruction, execute, writeback, illegal)
//
// Configuration
//   RISCV_DECODE_WB_BYPASS_EN : when defined, a same-cycle writeback to a
//   source register is forwarded into the operand and that source is not
//   treated as pending. When undefined, the dependent instruction waits one
//   cycle and reads the written register file value.
module riscv_decode (
  input  logic           clk,
  input  logic           rst_n,
  riscv_decode_if.slave  bus
);

  typedef logic [31:0] word_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Register file: x0 is never written and always read as zero.
  word_t rf_mem [32];

  // Scoreboard, one bit per architectural register x1..x31.
  logic [31:1] pending_q, pending_d;
  logic [31:1] pend_set, pend_clr;

  logic        ex_valid_q, ex_valid_d;
  word_t       ex_a_q, ex_a_d;
  word_t       ex_b_q, ex_b_d;
  logic        ex_is_imm_q, ex_is_imm_d;
  logic [6:0]  ex_funct7_q, ex_funct7_d;
  logic [2:0]  ex_funct3_q, ex_funct3_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        illegal_q, illegal_d;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign opcode = bus.inst[6:0];
  assign rd     = bus.inst[11:7];
  assign f3     = bus.inst[14:12];
  assign rs1    = bus.inst[19:15];
  assign rs2    = bus.inst[24:20];
  assign f7     = bus.inst[31:25];

  // Source reads, with optional forwarding from the writeback port
  word_t rs1_val, rs2_val;
  logic  rs1_fwd, rs2_fwd;

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf_mem[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf_mem[rs2];
`ifdef RISCV_DECODE_WB_BYPASS_EN
    rs1_fwd = bus.wb_en && (bus.wb_rd == rs1) && (rs1 != 5'd0);
    rs2_fwd = bus.wb_en && (bus.wb_rd == rs2) && (rs2 != 5'd0);
    if (rs1_fwd) rs1_val = bus.wb_data;
    if (rs2_fwd) rs2_val = bus.wb_data;
`else
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
`endif
  end

  // Decode and operand build
  logic       legal, use_rs1, use_rs2;
  word_t      dec_a, dec_b;
  logic       dec_is_imm;
  logic [6:0] dec_f7;
  logic [2:0] dec_f3;

  always_comb begin
    legal      = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec_a      = '0;
    dec_b      = '0;
    dec_is_imm = 1'b0;
    dec_f7     = '0;
    dec_f3     = '0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_a   = rs1_val;
        dec_b   = rs2_val;
        dec_f7  = f7;
        dec_f3  = f3;
        legal   = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) &&
                   ((f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        use_rs1    = 1'b1;
        dec_a      = rs1_val;
        dec_b      = {{20{bus.inst[31]}}, bus.inst[31:20]};
        dec_is_imm = 1'b1;
        dec_f3     = f3;
        // Only the shifts carry a meaningful funct7 in the immediate field.
        dec_f7     = ((f3 == 3'b001) || (f3 == 3'b101)) ? f7 : 7'b0000000;
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        legal      = 1'b1;
        dec_b      = {bus.inst[31:12], 12'b0};
        dec_is_imm = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Hazard: only legal instructions can stall; illegal ones are dropped
  // as soon as the output side has room.
  logic [31:0] pending_full;
  logic        hazard, accept, accept_legal;
  assign pending_full = {pending_q, 1'b0};
  assign hazard = legal &&
                  ((use_rs1 && pending_full[rs1] && !rs1_fwd) ||
                   (use_rs2 && pending_full[rs2] && !rs2_fwd));

  assign bus.inst_ready = (!ex_valid_q || bus.ex_ready) && !hazard;
  assign accept         = bus.inst_valid && bus.inst_ready;
  assign accept_legal   = accept && legal;

  // Scoreboard next state; a same-cycle set beats the writeback clear.
  for (genvar gi = 1; gi < 32; gi++) begin : g_pend
    assign pend_set[gi]  = accept_legal && (rd == 5'(gi));
    assign pend_clr[gi]  = bus.wb_en && (bus.wb_rd == 5'(gi));
    assign pending_d[gi] = pend_set[gi] || (pending_q[gi] && !pend_clr[gi]);
  end

  // Output register next state
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_is_imm_d = ex_is_imm_q;
    ex_funct7_d = ex_funct7_q;
    ex_funct3_d = ex_funct3_q;
    ex_rd_d     = ex_rd_q;
    illegal_d   = accept && !legal;
    if (accept_legal) begin
      ex_valid_d  = 1'b1;
      ex_a_d      = dec_a;
      ex_b_d      = dec_b;
      ex_is_imm_d = dec_is_imm;
      ex_funct7_d = dec_f7;
      ex_funct3_d = dec_f3;
      ex_rd_d     = rd;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_is_imm_q <= 1'b0;
      ex_funct7_q <= '0;
      ex_funct3_q <= '0;
      ex_rd_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      ex_valid_q  <= ex_valid_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_is_imm_q <= ex_is_imm_d;
      ex_funct7_q <= ex_funct7_d;
      ex_funct3_q <= ex_funct3_d;
      ex_rd_q     <= ex_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  // Register file storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      rf_mem[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_is_imm = ex_is_imm_q;
  assign bus.ex_funct7 = ex_funct7_q;
  assign bus.ex_funct3 = ex_funct3_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_decode.sv
// tb_riscv_decode
//   Directed testbench for riscv_decode. Drives instructions and writebacks
//   through riscv_decode_if and compares the issued payload against
//   hand-computed values. Timing expectations follow the build selected by
//   RISCV_DECODE_WB_BYPASS_EN.
module tb_riscv_decode;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  riscv_decode_if bus ();

  riscv_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI_X1   = 32'hFFB00093; // addi x1,x0,-5
  localparam logic [31:0] I_LUI_X2    = 32'h12345137; // lui  x2,0x12345
  localparam logic [31:0] I_SUB_X3    = 32'h401101B3; // sub  x3,x2,x1
  localparam logic [31:0] I_SRAI_X4   = 32'h4032D213; // srai x4,x5,3
  localparam logic [31:0] I_SLLI_BAD  = 32'h40101493; // slli x9,x0,1 with funct7 0100000
  localparam logic [31:0] I_ADD_X10   = 32'h00048533; // add  x10,x9,x0
  localparam logic [31:0] I_ADDI_X11  = 32'h00100593; // addi x11,x0,1
  localparam logic [31:0] I_ADDI_X12  = 32'h00200613; // addi x12,x0,2
  localparam logic [31:0] I_ADD_X6    = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] I_OR_X7     = 32'h000363B3; // or   x7,x6,x0
  localparam logic [31:0] I_ADD_X8    = 32'h00108433; // add  x8,x1,x1

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.ex_ready   = 1'b1;
    bus.wb_en      = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_data    = '0;
    tick();
    tick();
    check("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    check("rst_ex_a",      bus.ex_a,           32'd0);
    check("rst_ex_b",      bus.ex_b,           32'd0);
    check("rst_is_imm",    32'(bus.ex_is_imm), 32'd0);
    check("rst_funct7",    32'(bus.ex_funct7), 32'd0);
    check("rst_funct3",    32'(bus.ex_funct3), 32'd0);
    check("rst_rd",        32'(bus.ex_rd),     32'd0);
    check("rst_illegal",   32'(bus.illegal),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_inst_ready", 32'(bus.inst_ready), 32'd1);

    // addi x1,x0,-5
    bus.inst_valid = 1'b1;
    bus.inst       = I_ADDI_X1;
    tick();
    check("addi_valid",  32'(bus.ex_valid),  32'd1);
    check("addi_a",      bus.ex_a,           32'd0);
    check("addi_b",      bus.ex_b,           32'hFFFFFFFB);
    check("addi_is_imm", 32'(bus.ex_is_imm), 32'd1);
    check("addi_funct3", 32'(bus.ex_funct3), 32'd0);
    check("addi_funct7", 32'(bus.ex_funct7), 32'd0);
    check("addi_rd",     32'(bus.ex_rd),     32'd1);

    // lui x2, then sub x3,x2,x1 stalls on both sources
    bus.inst = I_LUI_X2;
    #1;
    check("lui_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    check("lui_b",      bus.ex_b,       32'h12345000);
    check("lui_a",      bus.ex_a,       32'd0);
    check("lui_rd",     32'(bus.ex_rd), 32'd2);
    bus.inst = I_SUB_X3;
    #1;
    check("sub_stall0", 32'(bus.inst_ready), 32'd0);
    tick();
    check("sub_stall1",     32'(bus.inst_ready), 32'd0);
    check("sub_stall_ev",   32'(bus.ex_valid),   32'd0);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd1;
    bus.wb_data = 32'd7;
    #1;
    check("sub_stall_wb1", 32'(bus.inst_ready), 32'd0);
    tick();
    bus.wb_rd   = 5'd2;
    bus.wb_data = 32'h12345000;
    #1;
`ifdef RISCV_DECODE_WB_BYPASS_EN
    check("sub_ready_wb2", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.wb_en      = 1'b0;
    bus.inst_valid = 1'b0;
`else
    check("sub_stall_wb2", 32'(bus.inst_ready), 32'd0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("sub_ready_after", 32'(bus.inst_ready), 32'd1);
    check("sub_not_yet",     32'(bus.ex_valid),   32'd0);
    tick();
    bus.inst_valid = 1'b0;
`endif
    check("sub_valid",  32'(bus.ex_valid),  32'd1);
    check("sub_a",      bus.ex_a,           32'h12345000);
    check("sub_b",      bus.ex_b,           32'd7);
    check("sub_funct7", 32'(bus.ex_funct7), 32'h20);
    check("sub_is_imm", 32'(bus.ex_is_imm), 32'd0);
    check("sub_rd",     32'(bus.ex_rd),     32'd3);

    // srai x4,x5,3
    bus.inst_valid = 1'b1;
    bus.inst       = I_SRAI_X4;
    tick();
    check("srai_funct7", 32'(bus.ex_funct7), 32'h20);
    check("srai_funct3", 32'(bus.ex_funct3), 32'd5);
    check("srai_b",      bus.ex_b,           32'h00000403);
    check("srai_b40",    32'(bus.ex_b[4:0]), 32'd3);

    // slli with funct7 0100000 is illegal
    bus.inst = I_SLLI_BAD;
    #1;
    check("slli_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    check("slli_illegal",  32'(bus.illegal),  32'd1);
    check("slli_no_issue", 32'(bus.ex_valid), 32'd0);
    tick();
    check("slli_pulse_end", 32'(bus.illegal), 32'd0);
    bus.inst = I_ADD_X10;
    #1;
    check("slli_no_pending", 32'(bus.inst_ready), 32'd1);

    // Back-pressure with two queued instructions
    bus.ex_ready   = 1'b0;
    bus.inst_valid = 1'b1;
    bus.inst       = I_ADDI_X11;
    tick();
    bus.inst = I_ADDI_X12;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready_%0d", i), 32'(bus.inst_ready), 32'd0);
      check($sformatf("bp_b_%0d", i),     bus.ex_b,            32'd1);
      check($sformatf("bp_rd_%0d", i),    32'(bus.ex_rd),      32'd11);
      tick();
    end
    bus.ex_ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    check("bp_second_b",  bus.ex_b,       32'd2);
    check("bp_second_rd", 32'(bus.ex_rd), 32'd12);

    // Issue add x6 in the same cycle as a writeback of x6: set wins
    bus.inst_valid = 1'b1;
    bus.inst       = I_ADD_X6;
    bus.wb_en      = 1'b1;
    bus.wb_rd      = 5'd6;
    bus.wb_data    = 32'h66;
    tick();
    bus.wb_en = 1'b0;
    check("add6_rd", 32'(bus.ex_rd), 32'd6);
    bus.inst = I_OR_X7;
    #1;
    check("or7_stall0", 32'(bus.inst_ready), 32'd0);
    tick();
    check("or7_stall1", 32'(bus.inst_ready), 32'd0);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd6;
    bus.wb_data = 32'h99;
    #1;
`ifdef RISCV_DECODE_WB_BYPASS_EN
    check("or7_ready_wb", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.wb_en      = 1'b0;
    bus.inst_valid = 1'b0;
`else
    check("or7_stall_wb", 32'(bus.inst_ready), 32'd0);
    tick();
    bus.wb_en = 1'b0;
    #1;
    check("or7_ready_after", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
`endif
    check("or7_valid",  32'(bus.ex_valid),  32'd1);
    check("or7_a",      bus.ex_a,           32'h99);
    check("or7_b",      bus.ex_b,           32'd0);
    check("or7_funct3", 32'(bus.ex_funct3), 32'd6);
    check("or7_rd",     32'(bus.ex_rd),     32'd7);

    // Reset mid-stall with a held payload and x1 pending
    bus.inst_valid = 1'b1;
    bus.inst       = I_ADDI_X1;
    tick();
    bus.inst_valid = 1'b0;
    bus.ex_ready   = 1'b0;
    check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(bus.ex_valid),  32'd0);
    check("arst_b",      bus.ex_b,           32'd0);
    check("arst_rd",     32'(bus.ex_rd),     32'd0);
    check("arst_is_imm", 32'(bus.ex_is_imm), 32'd0);
    bus.ex_ready   = 1'b1;
    bus.inst_valid = 1'b1;
    bus.inst       = I_ADD_X8;
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.inst_ready), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    check("add8_valid", 32'(bus.ex_valid), 32'd1);
    check("add8_rd",    32'(bus.ex_rd),    32'd8);
    check("add8_a",     bus.ex_a,          32'd7);
    check("add8_b",     bus.ex_b,          32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
